green_interp_pipe: RTL and testbench
====================================

GREEN_INTERP_PIPE -- requirements
Module: green_interp_pipe

Interface
REQ-001 Parameter PIXEL_W, default 12: pixel width in bits.
REQ-002 Parameter TH_W, default 8: threshold width in bits.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  input window valid.
REQ-006 in_ready  out  1  block accepts window this cycle.
REQ-007 is_green  in  1  centre pixel is a green Bayer site.
REQ-008 c  in  PIXEL_W  centre pixel.
REQ-009 h_m2, h_m1, h_p1, h_p2  in  PIXEL_W each  same-row neighbours at -2, -1, +1, +2.
REQ-010 v_m2, v_m1, v_p1, v_p2  in  PIXEL_W each  same-column neighbours at -2, -1, +1, +2.
REQ-011 th_lo, th_hi  in  TH_W each  runtime gradient thresholds, zero-extended for compares.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 green  out  PIXEL_W  interpolated green.
REQ-015 dir  out  2  decision code: 00 bypass, 01 average, 10 H-dominant, 11 V-dominant.

Function
REQ-016 Transfer occurs on in_valid && in_ready at input, and on out_valid && out_ready at output.
REQ-017 Pipeline is 3 stages; in_ready = !(out_valid && !out_ready); every stage, bubbles included, advances when in_ready=1 and holds otherwise.
REQ-018 Latency is exactly 3 cycles from input transfer to out_valid when not stalled; throughput is 1 window/cycle; no window is dropped or duplicated under stall.
REQ-019 Stage 1 computes, in signed PIXEL_W+4 bits: gh4 = 2*(h_m1+h_p1) + 2*c - h_m2 - h_p2, and gv4 the same over the v_* inputs.
REQ-020 Stage 1 computes unsigned gradients: dh = |h_m1-h_p1| + |2*c-h_m2-h_p2|, and dv the same over the v_* inputs.
REQ-021 Stage 2 computes gh = gh4 >>> 2 and gv = gv4 >>> 2 (arithmetic, floor), plus diff = |dh-dv|.
REQ-022 Dominant direction is H when dh <= dv (a tie selects H), else V; gd = dominant estimate, go = other estimate.
REQ-023 Decision priority: diff >= th_hi gives result gd; else diff < th_lo gives (gh+gv)>>>1 with dir=01; otherwise result (3*gd+go)>>>2.
REQ-024 For both the pure and the blend case, dir = 10 for H-dominant and 11 for V-dominant.
REQ-025 Stage 3 saturates the result to [0, 2^PIXEL_W-1].
REQ-026 is_green=1 outputs c unchanged with dir=00 and the same 3-cycle latency.
REQ-027 th_lo > th_hi is legal; REQ-023 priority resolves it, and the blend region is empty.
REQ-028 Thresholds are sampled with the window at input transfer and carried down the pipeline.
REQ-029 green and dir are stable while out_valid=1 and out_ready=0.

Reset
REQ-030 While rst=0 at a clock edge, all stage-valid bits clear; out_valid=0, green=0, dir=00.
REQ-031 in_ready=1 from the first cycle after reset deasserts.
REQ-032 Reset mid-stream discards every in-flight window; no output results from windows accepted before reset.

Configuration
REQ-033 Macro GREEN_INTERP_CLAMP_EN defined: after REQ-025, non-bypass results are clamped to [min, max] of {h_m1, h_p1, v_m1, v_p1}; latency is unchanged.
REQ-034 Macro GREEN_INTERP_CLAMP_EN undefined: no clamp logic is present; behaviour is exactly REQ-016..029.

Structure
REQ-035 Shared package gi_pkg holds the dir encodings (DIR_BYPASS, DIR_AVG, DIR_H, DIR_V) and the helper width constant EST_W = PIXEL_W+4.
REQ-036 One sub-module, gi_dir_est, computes the estimate numerator and the gradient for one direction; it is instantiated twice (H and V), is combinational, and feeds stage-1 registers.

Verification
REQ-037 Flat field, all inputs 1000, is_green=0, th_lo=16, th_hi=64 -> green=1000, dir=01, 3 cycles after input.
REQ-038 c=500, h_*=800, v_*=100, th 16/64 -> gh=650, gv=300, dh=600, dv=800, diff=200 -> green=650, dir=10.
REQ-039 Saturation, PIXEL_W=12: c=4095, h_m1=h_p1=v_m1=v_p1=4095, all ±2 neighbours 0 -> green=4095. Same with c=0, ±1 neighbours 0 and ±2 neighbours 4095 -> green=0.
REQ-040 Continuous stream of 20 windows, out_ready held low 5 cycles mid-stream -> all 20 outputs in order, none lost, outputs held stable during the stall.
REQ-041 is_green=1 with c=1234 and arbitrary neighbours -> green=1234, dir=00.
REQ-042 Assert rst=0 for one cycle with 2 windows in flight -> out_valid=0 next cycle; those 2 windows never appear at the output.

Source files
------------

// File: rtl/gi_pkg.sv
// ---------------------------------------------------------------------------
// gi_pkg -- shared definitions for the green interpolation pipeline.
//   DIR_*   : 2-bit decision codes driven on green_interp_pipe.dir
//   EST_W   : estimate/gradient width for the default 12-bit pixel
//   est_w() : same width rule for any pixel width (pixel + 4 guard bits)
// ---------------------------------------------------------------------------
package gi_pkg;

   localparam logic [1:0] DIR_BYPASS = 2'b00;
   localparam logic [1:0] DIR_AVG    = 2'b01;
   localparam logic [1:0] DIR_H      = 2'b10;
   localparam logic [1:0] DIR_V      = 2'b11;

   localparam int PIXEL_W_DEF = 12;
   localparam int EST_W       = PIXEL_W_DEF + 4;

   // Four guard bits hold 6x pixel max (numerator) and the sign.
   function automatic int est_w(input int pixel_w);
      return pixel_w + 4;
   endfunction

endpackage

// File: rtl/gi_dir_est.sv
// ---------------------------------------------------------------------------
// gi_dir_est -- combinational estimate for one direction (H or V).
//   c, m2, m1, p1, p2 : centre and neighbours at -2, -1, +1, +2
//   num  : signed 4x estimate  2*(m1+p1) + 2*c - m2 - p2
//   grad : unsigned gradient   |m1-p1| + |2*c - m2 - p2|
// ---------------------------------------------------------------------------
module gi_dir_est
   import gi_pkg::*;
#(
   parameter  int PIXEL_W = 12,
   localparam int EW      = est_w(PIXEL_W)
) (
   input  logic [PIXEL_W-1:0]   c,
   input  logic [PIXEL_W-1:0]   m2,
   input  logic [PIXEL_W-1:0]   m1,
   input  logic [PIXEL_W-1:0]   p1,
   input  logic [PIXEL_W-1:0]   p2,
   output logic signed [EW-1:0] num,
   output logic [EW-1:0]        grad
);

   logic signed [EW-1:0] cs, m2s, m1s, p1s, p2s;
   logic signed [EW-1:0] d1, d2, a1, a2;

   always_comb begin
      cs   = $signed(EW'(c));
      m2s  = $signed(EW'(m2));
      m1s  = $signed(EW'(m1));
      p1s  = $signed(EW'(p1));
      p2s  = $signed(EW'(p2));
      num  = ((m1s + p1s + cs) <<< 1) - m2s - p2s;
      d1   = m1s - p1s;
      d2   = (cs <<< 1) - m2s - p2s;
      a1   = d1[EW-1] ? -d1 : d1;
      a2   = d2[EW-1] ? -d2 : d2;
      grad = $unsigned(a1 + a2);
   end

endmodule

// File: rtl/green_interp_pipe.sv
// ---------------------------------------------------------------------------
// green_interp_pipe -- 3-stage gradient-directed green interpolation.
//   clk, rst            : clock, synchronous active-low reset
//   in_valid/in_ready   : window handshake (c, h_*, v_*, is_green, th_lo/hi)
//   out_valid/out_ready : result handshake (green, dir)
// Stage 1: per-direction estimates and gradients (two gi_dir_est).
// Stage 2: /4 estimates, gradient difference, dominant direction.
// Stage 3: threshold decision, saturation, optional clamp.
// Build option: define GREEN_INTERP_CLAMP_EN to clamp non-bypass results to
// the range of the four nearest neighbours.
// ---------------------------------------------------------------------------
module green_interp_pipe
   import gi_pkg::*;
#(
   parameter int PIXEL_W = 12,
   parameter int TH_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               is_green,
   input  logic [PIXEL_W-1:0] c,
   input  logic [PIXEL_W-1:0] h_m2,
   input  logic [PIXEL_W-1:0] h_m1,
   input  logic [PIXEL_W-1:0] h_p1,
   input  logic [PIXEL_W-1:0] h_p2,
   input  logic [PIXEL_W-1:0] v_m2,
   input  logic [PIXEL_W-1:0] v_m1,
   input  logic [PIXEL_W-1:0] v_p1,
   input  logic [PIXEL_W-1:0] v_p2,
   input  logic [TH_W-1:0]    th_lo,
   input  logic [TH_W-1:0]    th_hi,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIXEL_W-1:0] green,
   output logic [1:0]         dir
);

   localparam int EW     = est_w(PIXEL_W);
   localparam int RW     = EW + 2;   // headroom for 3*gd + go
   localparam int STAGES = 3;
   localparam logic signed [RW-1:0] PMAX =
      $signed({{(RW-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}});

   // vld_pipe[0] is the incoming valid, [STAGES] is out_valid
   logic [STAGES:1] vld_q;
   logic [STAGES:0] vld_pipe;

   always_comb vld_pipe = {vld_q, in_valid};

   assign out_valid = vld_pipe[STAGES];
   // Whole pipe moves in lockstep; only a blocked output stalls it.
   assign in_ready  = !(out_valid && !out_ready);

   // ---------------- stage 1 ----------------
   logic signed [EW-1:0] gh4_n, gv4_n;
   logic [EW-1:0]        dh_n, dv_n;

   gi_dir_est #(.PIXEL_W(PIXEL_W)) u_est_h (
      .c(c), .m2(h_m2), .m1(h_m1), .p1(h_p1), .p2(h_p2),
      .num(gh4_n), .grad(dh_n)
   );

   gi_dir_est #(.PIXEL_W(PIXEL_W)) u_est_v (
      .c(c), .m2(v_m2), .m1(v_m1), .p1(v_p1), .p2(v_p2),
      .num(gv4_n), .grad(dv_n)
   );

   logic signed [EW-1:0] s1_gh4, s1_gv4;
   logic [EW-1:0]        s1_dh, s1_dv;
   logic [PIXEL_W-1:0]   s1_c;
   logic                 s1_byp;
   logic [TH_W-1:0]      s1_tlo, s1_thi;

`ifdef GREEN_INTERP_CLAMP_EN
   logic [PIXEL_W-1:0] cmin_n, cmax_n, s1_cmin, s1_cmax, s2_cmin, s2_cmax;
   logic [PIXEL_W-1:0] lo_h, lo_v, hi_h, hi_v;

   always_comb begin
      lo_h   = (h_m1 < h_p1) ? h_m1 : h_p1;
      hi_h   = (h_m1 < h_p1) ? h_p1 : h_m1;
      lo_v   = (v_m1 < v_p1) ? v_m1 : v_p1;
      hi_v   = (v_m1 < v_p1) ? v_p1 : v_m1;
      cmin_n = (lo_h < lo_v) ? lo_h : lo_v;
      cmax_n = (hi_h > hi_v) ? hi_h : hi_v;
   end
`endif

   // ---------------- stage 2 ----------------
   logic signed [EW-1:0] s2_gh, s2_gv;
   logic [EW-1:0]        s2_diff;
   logic                 s2_hdom;
   logic [PIXEL_W-1:0]   s2_c;
   logic                 s2_byp;
   logic [TH_W-1:0]      s2_tlo, s2_thi;

   // Datapath registers carry no reset; validity lives in vld_q.
   always_ff @(posedge clk) begin
      if (in_ready) begin
         s1_gh4  <= gh4_n;
         s1_gv4  <= gv4_n;
         s1_dh   <= dh_n;
         s1_dv   <= dv_n;
         s1_c    <= c;
         s1_byp  <= is_green;
         s1_tlo  <= th_lo;
         s1_thi  <= th_hi;

         s2_gh   <= s1_gh4 >>> 2;
         s2_gv   <= s1_gv4 >>> 2;
         s2_diff <= (s1_dh >= s1_dv) ? (s1_dh - s1_dv) : (s1_dv - s1_dh);
         s2_hdom <= (s1_dh <= s1_dv);     // tie resolves to H
         s2_c    <= s1_c;
         s2_byp  <= s1_byp;
         s2_tlo  <= s1_tlo;
         s2_thi  <= s1_thi;
`ifdef GREEN_INTERP_CLAMP_EN
         s1_cmin <= cmin_n;
         s1_cmax <= cmax_n;
         s2_cmin <= s1_cmin;
         s2_cmax <= s1_cmax;
`endif
      end
   end

   // ---------------- stage 3 ----------------
   logic signed [RW-1:0] ghx, gvx, gdx, gox, res;
   logic [PIXEL_W-1:0]   s3_green;
   logic [1:0]           s3_dir;

   always_comb begin
      ghx    = RW'(s2_gh);
      gvx    = RW'(s2_gv);
      gdx    = s2_hdom ? ghx : gvx;
      gox    = s2_hdom ? gvx : ghx;
      s3_dir = s2_hdom ? DIR_H : DIR_V;
      // th_hi is tested first so th_lo > th_hi leaves no blend region
      if (s2_diff >= EW'(s2_thi)) begin
         res = gdx;
      end else if (s2_diff < EW'(s2_tlo)) begin
         res    = (ghx + gvx) >>> 1;
         s3_dir = DIR_AVG;
      end else begin
         res = ((gdx <<< 1) + gdx + gox) >>> 2;
      end

      if (res[RW-1])       s3_green = '0;
      else if (res > PMAX) s3_green = '1;
      else                 s3_green = res[PIXEL_W-1:0];

`ifdef GREEN_INTERP_CLAMP_EN
      if (s3_green < s2_cmin)      s3_green = s2_cmin;
      else if (s3_green > s2_cmax) s3_green = s2_cmax;
`endif

      if (s2_byp) begin
         s3_green = s2_c;
         s3_dir   = DIR_BYPASS;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
         green <= '0;
         dir   <= DIR_BYPASS;
      end else if (in_ready) begin
         vld_q <= vld_pipe[STAGES-1:0];
         green <= s3_green;
         dir   <= s3_dir;
      end
   end

endmodule

// File: tb/tb_green_interp_pipe.sv
module tb_green_interp_pipe;

   localparam int PW = 12;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, is_green;
   logic [PW-1:0] c, h_m2, h_m1, h_p1, h_p2, v_m2, v_m1, v_p1, v_p2;
   logic [TW-1:0] th_lo, th_hi;
   logic          out_valid, out_ready;
   logic [PW-1:0] green;
   logic [1:0]    dir;

   green_interp_pipe #(.PIXEL_W(PW), .TH_W(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .is_green(is_green), .c(c),
      .h_m2(h_m2), .h_m1(h_m1), .h_p1(h_p1), .h_p2(h_p2),
      .v_m2(v_m2), .v_m1(v_m1), .v_p1(v_p1), .v_p2(v_p2),
      .th_lo(th_lo), .th_hi(th_hi),
      .out_valid(out_valid), .out_ready(out_ready),
      .green(green), .dir(dir)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c, hm2, hm1, hp1, hp2, vm2, vm1, vp1, vp2, tlo, thi;
      bit g;
   } win_t;

   typedef struct {
      int g;
      int d;
      int cyc;
   } exp_t;

   exp_t          q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;
   bit            lat_chk = 0, ovr_en = 0, hold_chk = 0, acc = 0;
   int            ovr_g, ovr_d;
   logic [PW-1:0] hold_g;
   logic [1:0]    hold_d;
   win_t          cur;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Reference: plain integer arithmetic straight from the interpolation rules.
   function automatic void model(input win_t w, output int g, output int d);
      int gh, gv, dh, dv, diff, gd, go, r, lo, hi;
      bit hd;
      if (w.g) begin
         g = w.c;
         d = 0;
         return;
      end
      gh   = (2*(w.hm1 + w.hp1) + 2*w.c - w.hm2 - w.hp2) >>> 2;
      gv   = (2*(w.vm1 + w.vp1) + 2*w.c - w.vm2 - w.vp2) >>> 2;
      dh   = iabs(w.hm1 - w.hp1) + iabs(2*w.c - w.hm2 - w.hp2);
      dv   = iabs(w.vm1 - w.vp1) + iabs(2*w.c - w.vm2 - w.vp2);
      diff = iabs(dh - dv);
      hd   = (dh <= dv);
      gd   = hd ? gh : gv;
      go   = hd ? gv : gh;
      d    = hd ? 2 : 3;
      if (diff >= w.thi)      r = gd;
      else if (diff < w.tlo) begin r = (gh + gv) >>> 1; d = 1; end
      else                    r = (3*gd + go) >>> 2;
      if (r < 0)        r = 0;
      if (r > 4095)     r = 4095;
`ifdef GREEN_INTERP_CLAMP_EN
      lo = w.hm1; hi = w.hm1;
      foreach (int'(0)[i]) ;
      if (w.hp1 < lo) lo = w.hp1;  if (w.hp1 > hi) hi = w.hp1;
      if (w.vm1 < lo) lo = w.vm1;  if (w.vm1 > hi) hi = w.vm1;
      if (w.vp1 < lo) lo = w.vp1;  if (w.vp1 > hi) hi = w.vp1;
      if (r < lo) r = lo;
      if (r > hi) r = hi;
`else
      lo = 0; hi = 0;
`endif
      g = r + 0 * (lo + hi);
   endfunction

   function automatic int clip(input int x);
      return (x < 0) ? 0 : (x > 4095) ? 4095 : x;
   endfunction

   function automatic win_t rand_win();
      win_t w;
      int   base, m, sp;
      base = $urandom_range(0, 4095);
      m    = $urandom_range(0, 2);
      sp   = (m == 0) ? 4095 : 48;
      w.c   = clip(base + $urandom_range(0, sp) - sp/2);
      w.hm2 = clip(base + $urandom_range(0, sp) - sp/2);
      w.hm1 = clip(base + $urandom_range(0, sp) - sp/2);
      w.hp1 = clip(base + $urandom_range(0, sp) - sp/2);
      w.hp2 = clip(base + $urandom_range(0, sp) - sp/2);
      if (m == 2) sp = 600;
      w.vm2 = clip(base + $urandom_range(0, sp) - sp/2);
      w.vm1 = clip(base + $urandom_range(0, sp) - sp/2);
      w.vp1 = clip(base + $urandom_range(0, sp) - sp/2);
      w.vp2 = clip(base + $urandom_range(0, sp) - sp/2);
      w.tlo = $urandom_range(0, 255);
      w.thi = $urandom_range(0, 255);
      w.g   = ($urandom_range(0, 7) == 0);
      return w;
   endfunction

   function automatic win_t mk(input int cc, input int h2, input int h1, input int v2,
                               input int v1, input bit g);
      win_t w;
      w.c = cc; w.hm2 = h2; w.hp2 = h2; w.hm1 = h1; w.hp1 = h1;
      w.vm2 = v2; w.vp2 = v2; w.vm1 = v1; w.vp1 = v1;
      w.tlo = 16; w.thi = 64; w.g = g;
      return w;
   endfunction

   task automatic apply(input win_t w);
      cur      = w;
      c        = PW'(w.c);
      h_m2     = PW'(w.hm2); h_m1 = PW'(w.hm1); h_p1 = PW'(w.hp1); h_p2 = PW'(w.hp2);
      v_m2     = PW'(w.vm2); v_m1 = PW'(w.vm1); v_p1 = PW'(w.vp1); v_p2 = PW'(w.vp2);
      th_lo    = TW'(w.tlo);
      th_hi    = TW'(w.thi);
      is_green = w.g;
   endtask

   // One clock: sample handshakes mid-cycle, score, then move past the edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      acc = 0;
      if (hold_chk) begin
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_green", 32'(green), 32'(hold_g));
         chk("hold_dir",   32'(dir),   32'(hold_d));
      end
      hold_chk = rst && out_valid && !out_ready;
      hold_g   = green;
      hold_d   = dir;
      if (rst && out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
         else begin
            e = q.pop_front();
            chk("green", 32'(green), e.g);
            chk("dir",   32'(dir),   e.d);
            if (lat_chk) chk("latency", cyc - e.cyc, 3);
         end
      end
      if (rst && in_valid && in_ready) begin
         acc = 1;
         if (ovr_en) begin e.g = ovr_g; e.d = ovr_d; end
         else model(cur, e.g, e.d);
         e.cyc = cyc;
         q.push_back(e);
      end
      if (!rst) q.delete();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input win_t w, input int eg, input int ed);
      apply(w);
      in_valid = 1'b1; ovr_en = 1'b1; ovr_g = eg; ovr_d = ed;
      tick();
      in_valid = 1'b0; ovr_en = 1'b0;
      repeat (4) tick();
      chk("directed_drained", q.size(), 0);
   endtask

   initial begin
      int n;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 1'b0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_green",     32'(green), 0);
      chk("rst_dir",       32'(dir), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 32'(in_ready), 1);
      @(posedge clk); #1;

      // directed windows, idle pipe, exact latency
      lat_chk = 1'b1;
      directed(mk(1000, 1000, 1000, 1000, 1000, 1'b0), 1000, 1);
      directed(mk(500, 800, 800, 100, 100, 1'b0), 650, 2);
      directed(mk(4095, 0, 4095, 0, 4095, 1'b0), 4095, 1);
      directed(mk(0, 4095, 0, 4095, 0, 1'b0), 0, 1);
      directed(mk(1234, 17, 3000, 4000, 9, 1'b1), 1234, 0);

      // back-to-back stream, output stalled 5 cycles mid-stream
      lat_chk = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && n < 20; i++) begin
         out_ready = !(i >= 8 && i < 13);
         apply(rand_win());
         in_valid = 1'b1;
         tick();
         if (acc) n++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_accepted", n, 20);
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      chk("stream_drained", q.size(), 0);

      // reset with two windows in flight
      for (int i = 0; i < 2; i++) begin
         apply(rand_win());
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_green",     32'(green), 0);
      repeat (6) tick();

      // random traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         apply(rand_win());
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      chk("final_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
